// File: rtl/cordic_pkg.sv
// Shared constants for the vectoring CORDIC: controller states, the arctangent
// table in binary-angle units for a 14-bit angle, and the half-circle constant.
package cordic_pkg;

  localparam int LUT_AW = 14;
  localparam int CNT_W  = 4;

  localparam logic [LUT_AW-1:0] ANG_PI = LUT_AW'(1) << (LUT_AW - 1);

  typedef enum logic [2:0] {
    IDLE,
    MAP,
    ITER,
    FIX,
    DONE
  } state_e;

  // atan(2^-i) scaled so that a full turn is 2^14.
  function automatic logic [LUT_AW-1:0] atan_lut(input logic [CNT_W-1:0] idx);
    logic [LUT_AW-1:0] val;
    case (idx)
      4'd0:    val = 14'd2048;
      4'd1:    val = 14'd1209;
      4'd2:    val = 14'd639;
      4'd3:    val = 14'd324;
      4'd4:    val = 14'd163;
      4'd5:    val = 14'd81;
      4'd6:    val = 14'd41;
      4'd7:    val = 14'd20;
      4'd8:    val = 14'd10;
      4'd9:    val = 14'd5;
      4'd10:   val = 14'd3;
      4'd11:   val = 14'd1;
      default: val = '0;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/cordic_iter_stage.sv
// One combinational vectoring micro-rotation; the controller feeds it back
// through its own registers, so a single adder set serves every iteration.
module cordic_iter_stage
  import cordic_pkg::*;
#(
  parameter int XW = 14,
  parameter int AW = 14
) (
  input  logic signed [XW-1:0]    x_i,
  input  logic signed [XW-1:0]    y_i,
  input  logic signed [AW-1:0]    z_i,
  input  logic        [CNT_W-1:0] idx_i,
  output logic signed [XW-1:0]    x_o,
  output logic signed [XW-1:0]    y_o,
  output logic signed [AW-1:0]    z_o
);

  logic signed [XW-1:0] x_sh;
  logic signed [XW-1:0] y_sh;
  logic signed [AW-1:0] atan;

  always_comb begin
    // Both shifts use the incoming values, giving the simultaneous update.
    x_sh = x_i >>> idx_i;
    y_sh = y_i >>> idx_i;
    atan = AW'(atan_lut(idx_i));
    if (!y_i[XW-1]) begin
      x_o = x_i + y_sh;
      y_o = y_i - x_sh;
      z_o = z_i + atan;
    end else begin
      x_o = x_i - y_sh;
      y_o = y_i + x_sh;
      z_o = z_i - atan;
    end
  end

endmodule

// File: rtl/cordic_vec_ctrl.sv
// Iterative vectoring CORDIC controller: (X, Y) in, phase and magnitude out.
// Define CORDIC_GAIN_COMP_EN to scale the magnitude by 1/K before it is output.
module cordic_vec_ctrl
  import cordic_pkg::*;
#(
  parameter int W  = 12,
  parameter int N  = 12,
  parameter int AW = 14
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic signed [W-1:0]  x_in,
  input  logic signed [W-1:0]  y_in,
  output logic                 busy,
  output logic                 done,
  output logic signed [AW-1:0] angle_out,
  output logic        [W+1:0]  mag_out
);

  localparam int XW = W + 2;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic signed [XW-1:0] x_q, x_d;
  logic signed [XW-1:0] y_q, y_d;
  logic signed [AW-1:0] z_q, z_d;
  logic                 neg_q, neg_d;
  logic                 zero_q, zero_d;
  logic                 yzero_q, yzero_d;
  logic signed [AW-1:0] angle_q, angle_d;
  logic [XW-1:0]        mag_q, mag_d;

  logic signed [XW-1:0] x_nx;
  logic signed [XW-1:0] y_nx;
  logic signed [AW-1:0] z_nx;
  logic [XW-1:0]        x_u;
  logic [XW-1:0]        mag_fix;

  cordic_iter_stage #(
    .XW(XW),
    .AW(AW)
  ) u_iter (
    .x_i  (x_q),
    .y_i  (y_q),
    .z_i  (z_q),
    .idx_i(cnt_q),
    .x_o  (x_nx),
    .y_o  (y_nx),
    .z_o  (z_nx)
  );

  assign x_u = x_q;

  always_comb begin
`ifdef CORDIC_GAIN_COMP_EN
    mag_fix = (x_u >> 1) + (x_u >> 3) - (x_u >> 6) - (x_u >> 9);
`else
    mag_fix = x_u;
`endif
  end

  always_comb begin
    // NOTE: every variable gets its hold value first so no path infers a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    neg_d   = neg_q;
    zero_d  = zero_q;
    yzero_d = yzero_q;
    angle_d = angle_q;
    mag_d   = mag_q;
    busy    = (state_q != IDLE);
    done    = (state_q == DONE);

    case (state_q)
      IDLE: begin
        if (start) begin
          x_d     = {{2{x_in[W-1]}}, x_in};
          y_d     = {{2{y_in[W-1]}}, y_in};
          z_d     = '0;
          cnt_d   = '0;
          zero_d  = (x_in == '0) && (y_in == '0);
          yzero_d = (y_in == '0);
          state_d = MAP;
        end
      end
      MAP: begin
        // Rotate left-half-plane vectors by pi; the extra bits absorb -(-2^(W-1)).
        if (x_q[XW-1]) begin
          x_d   = -x_q;
          y_d   = -y_q;
          neg_d = 1'b1;
        end else begin
          neg_d = 1'b0;
        end
        cnt_d   = '0;
        state_d = ITER;
      end
      ITER: begin
        x_d = x_nx;
        y_d = y_nx;
        z_d = z_nx;
        if (cnt_q == CNT_W'(N - 1)) begin
          state_d = FIX;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      FIX: begin
        // Axis-aligned inputs bypass the LUT residue so 0 and pi come out exact.
        if (zero_q) begin
          angle_d = '0;
          mag_d   = '0;
        end else if (yzero_q) begin
          angle_d = neg_q ? AW'(ANG_PI) : '0;
          mag_d   = mag_fix;
        end else begin
          angle_d = {z_q[AW-1] ^ neg_q, z_q[AW-2:0]};
          mag_d   = mag_fix;
        end
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      neg_q   <= 1'b0;
      zero_q  <= 1'b0;
      yzero_q <= 1'b0;
      angle_q <= '0;
      mag_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      neg_q   <= neg_d;
      zero_q  <= zero_d;
      yzero_q <= yzero_d;
      angle_q <= angle_d;
      mag_q   <= mag_d;
    end
  end

  assign angle_out = angle_q;
  assign mag_out   = mag_q;

endmodule

// File: tb/tb_cordic_vec_ctrl.sv
// Directed bench for cordic_vec_ctrl: hand-computed angles/magnitudes,
// latency, start-while-busy rejection and mid-operation reset.
module tb_cordic_vec_ctrl;

  localparam int W  = 12;
  localparam int N  = 12;
  localparam int AW = 14;
  localparam int LAT = N + 3;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start;
  logic signed [W-1:0]  x_in;
  logic signed [W-1:0]  y_in;
  logic                 busy;
  logic                 done;
  logic signed [AW-1:0] angle_out;
  logic [W+1:0]         mag_out;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    int    x;
    int    y;
    int    ang;
    int    ang_tol;
    int    mag;
    int    mag_tol;
    string name;
  } vec_t;

`ifdef CORDIC_GAIN_COMP_EN
  localparam int M1000 = 1000;
  localparam int M1414 = 1414;
  localparam int M2896 = 2896;
`else
  localparam int M1000 = 1647;
  localparam int M1414 = 2329;
  localparam int M2896 = 4770;
`endif

  vec_t vecs[7] = '{
    '{ 1000,     0,     0, 2, M1000, 4, "x_pos"},
    '{    0,  1000,  4096, 2, M1000, 4, "y_pos"},
    '{    0, -1000, -4096, 2, M1000, 4, "y_neg"},
    '{-1000,     0, -8192, 0, M1000, 4, "x_neg_pi"},
    '{-1000, -1000, -6144, 2, M1414, 4, "q3"},
    '{-2048, -2048, -6144, 2, M2896, 6, "extreme"},
    '{    0,     0,     0, 0,     0, 0, "origin"}
  };

  always #5 clk = ~clk;

  cordic_vec_ctrl #(
    .W (W),
    .N (N),
    .AW(AW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .x_in     (x_in),
    .y_in     (y_in),
    .busy     (busy),
    .done     (done),
    .angle_out(angle_out),
    .mag_out  (mag_out)
  );

  task automatic check(input string tag, input int obs, input int exp, input int tol);
    int diff;
    n_vec++;
    diff = obs - exp;
    if (diff < 0) diff = -diff;
    if (diff > tol) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (tol %0d)", tag, obs, exp, tol);
    end
  endtask

  // Returns the number of edges from the accepting edge through the edge
  // that raises done, inclusive; a value past the bound means no done.
  task automatic run_op(input int xv, input int yv, input bit inject, output int cycles);
    @(negedge clk);
    x_in  = W'(xv);
    y_in  = W'(yv);
    start = 1'b1;
    @(posedge clk);
    cycles = 1;
    while (cycles < 40) begin
      @(negedge clk);
      if (done) break;
      start = inject && (cycles == 3 || cycles == 14);
      if (start) begin
        x_in = 12'sd300;
        y_in = -12'sd700;
      end
      @(posedge clk);
      cycles++;
    end
    if (inject) begin
      start = 1'b1;
      x_in  = 12'sd300;
      y_in  = -12'sd700;
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic count_dones(input int span, output int n);
    n = 0;
    repeat (span) begin
      @(negedge clk);
      if (done) n++;
    end
  endtask

  initial begin
    int lat;
    int extra;

    rst   = 1'b1;
    start = 1'b0;
    x_in  = '0;
    y_in  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy",  int'(busy),      0, 0);
    check("rst_done",  int'(done),      0, 0);
    check("rst_angle", int'(angle_out), 0, 0);
    check("rst_mag",   int'(mag_out),   0, 0);
    rst = 1'b0;

    foreach (vecs[k]) begin
      run_op(vecs[k].x, vecs[k].y, 1'b0, lat);
      check({vecs[k].name, "_lat"},   lat,                 LAT,            0);
      check({vecs[k].name, "_angle"}, int'(angle_out),     vecs[k].ang,    vecs[k].ang_tol);
      check({vecs[k].name, "_mag"},   int'(mag_out),       vecs[k].mag,    vecs[k].mag_tol);
      check({vecs[k].name, "_idle"},  int'(busy),          0,              0);
    end

    // Extra start pulses during ITER, FIX and DONE must be dropped.
    run_op(-1000, -1000, 1'b1, lat);
    check("inject_lat",   lat,             LAT,   0);
    check("inject_angle", int'(angle_out), -6144, 2);
    check("inject_mag",   int'(mag_out),   M1414, 4);
    count_dones(25, extra);
    check("inject_extra_done", extra,           0,     0);
    check("inject_hold_angle", int'(angle_out), -6144, 2);

    // Reset asserted while the counter is at iteration 5.
    @(negedge clk);
    x_in  = 12'sd1000;
    y_in  = 12'sd0;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("pre_rst_busy", int'(busy), 1, 0);
    rst = 1'b1;
    #1;
    check("mid_rst_busy",  int'(busy),      0, 0);
    check("mid_rst_done",  int'(done),      0, 0);
    check("mid_rst_angle", int'(angle_out), 0, 0);
    check("mid_rst_mag",   int'(mag_out),   0, 0);
    @(negedge clk);
    rst = 1'b0;
    count_dones(20, extra);
    check("mid_rst_no_done", extra, 0, 0);

    run_op(0, 1000, 1'b0, lat);
    check("post_rst_lat",   lat,             LAT,   0);
    check("post_rst_angle", int'(angle_out), 4096,  2);
    check("post_rst_mag",   int'(mag_out),   M1000, 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
